mux_scan_capture: RTL and testbench
===================================

MUX_SCAN_CAPTURE -- requirements
Module: mux_scan_capture

Interface
REQ-001 Parameter DWELL, default 2: clock cycles each select code is held before the mux output is sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one scan of channels 0..3; sampled only in IDLE.
REQ-005 cont  input  1  continuous mode; when high, a new scan begins automatically after each word is accepted.
REQ-006 y  input  1  output of the downstream 4:1 select stage being scanned.
REQ-007 sel1  output  1  select MSB driven to the 4:1 stage.
REQ-008 sel2  output  1  select LSB driven to the 4:1 stage.
REQ-009 data_out  output  4  captured word; bit k = y sampled while channel k was selected.
REQ-010 out_valid  output  1  data_out holds a complete word.
REQ-011 out_ready  input  1  consumer accepts data_out when high together with out_valid.
REQ-012 busy  output  1  high in SCAN and HOLD.

Function
REQ-013 The block SHALL implement three states: IDLE, SCAN, HOLD.
REQ-014 Channel k (0..3) SHALL drive {sel1,sel2} = k in binary: ch0=00, ch1=01, ch2=10, ch3=11.
REQ-015 IDLE: {sel1,sel2}=00, out_valid=0, busy=0; start=1 on an edge moves to SCAN with channel=0, dwell count=0.
REQ-016 SCAN: dwell counter ($clog2(DWELL+1) bits) increments each edge; on the edge where count==DWELL-1, y SHALL be written into data_out[channel], count SHALL clear, channel SHALL increment.
REQ-017 Sampling on the last dwell edge of channel 3 SHALL move to HOLD and set out_valid=1 on that same edge.
REQ-018 Latency: out_valid SHALL rise exactly 4*DWELL rising edges after the edge that accepted start.
REQ-019 The select outputs SHALL be registered and change only on the edge that advances the channel; no glitch within a dwell window.
REQ-020 HOLD: data_out and out_valid SHALL remain stable until a cycle with out_valid=1 and out_ready=1 (transfer).
REQ-021 On transfer with cont=0: next state IDLE, out_valid=0, data_out retains last word.
REQ-022 On transfer with cont=1: next state SCAN at channel 0 with no idle cycle; out_valid=0 on that edge.
REQ-023 start asserted in SCAN or HOLD SHALL be ignored (no restart, no queueing).
REQ-024 cont deasserted mid-scan SHALL not abort the current scan; it is evaluated only at transfer.
REQ-025 data_out bits not yet sampled in a new scan SHALL hold their previous values; only out_valid qualifies the word.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 DWELL=1 SHALL sample every edge (one cycle per channel, 4-cycle scan).

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force IDLE, channel=0, count=0, sel1=0, sel2=0, data_out=4'b0000, out_valid=0, busy=0.
REQ-029 reset asserted mid-SCAN or in HOLD SHALL discard the partial/pending word; after release the block waits for start (or cont alone does not start it).
REQ-030 First start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-031 DWELL=2, y driven by a model 4:1 mux with i0..i3=1,0,1,1, start pulse -> sel sequence 00,00,01,01,10,10,11,11; out_valid at edge 8; data_out=4'b1101.
REQ-032 Same stimulus, out_ready held low 5 cycles after out_valid -> data_out=4'b1101 and out_valid stable 5 cycles, drop one edge after out_ready=1.
REQ-033 cont=1, out_ready=1, inputs changed to i0..i3=0,1,1,0 during second scan -> back-to-back scans with no IDLE cycle; second word 4'b0110.
REQ-034 reset pulsed during channel 2 of a scan -> all outputs zero at once; no out_valid until a new start; following scan correct.
REQ-035 start pulsed during SCAN and HOLD -> ignored; exactly one word produced.
REQ-036 DWELL=1, i0..i3=0,0,0,1 -> out_valid at edge 4, data_out=4'b1000.

Source files
------------

// File: rtl/mux_scan_capture.sv
// Scans a 4:1 select stage one channel at a time and assembles the four y
// samples into a word. The word is held with out_valid until the consumer takes it.
module mux_scan_capture #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic       sel1,
  output logic       sel2,
  output logic [3:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  localparam int CW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ch;
  logic [CW-1:0]   cnt;
  logic            last;

  assign last = (cnt == CW'(DWELL - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)                       state_nxt = SCAN;
      SCAN: if (last && ch == 2'd3)          state_nxt = HOLD;
      HOLD: if (out_ready)                   state_nxt = cont ? SCAN : IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // ch doubles as the registered select, so sel only moves on a sampling edge;
  // it wraps to 0 after channel 3, which is the select value in HOLD and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        SCAN: begin
          if (last) begin
            data_out[ch] <= y;
            cnt          <= '0;
            ch           <= ch + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          ch  <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  assign {sel1, sel2} = ch;
  assign out_valid    = (state == HOLD);
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: directed vector table, hand-written corner
// sequences and random traffic against a time-based reference model.
module tb_mux_scan_capture;
  localparam int DW = 2;

  logic       clk = 1'b0;
  logic       reset, start, cont, out_ready, y;
  logic [3:0] in_i;
  logic       sel1, sel2, out_valid, busy;
  logic [3:0] data_out;

  logic       start1, out_ready1, y1;
  logic [3:0] in1;
  logic       s1a, s1b, v1, b1;
  logic [3:0] d1;

  always #5 clk = ~clk;

  assign y  = in_i[{sel1, sel2}];
  assign y1 = in1[{s1a, s1b}];

  mux_scan_capture #(.DWELL(DW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .y(y),
    .sel1(sel1), .sel2(sel2), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy));

  mux_scan_capture #(.DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .cont(1'b0), .y(y1),
    .sel1(s1a), .sel2(s1b), .data_out(d1), .out_valid(v1),
    .out_ready(out_ready1), .busy(b1));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: elapsed edges since the scan began decide everything
  bit         m_busy, m_valid;
  int         t;
  logic [3:0] m_data;

  typedef struct {
    bit s, c, r;
    logic [3:0] iv;
    logic [1:0] sel;
    bit v, b;
    logic [3:0] d;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_valid = 0; t = 0; m_data = 4'b0000;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit r, input logic [3:0] iv);
    if (m_busy) begin
      t++;
      if (t % DW == 0) m_data[t/DW-1] = iv[t/DW-1];
      if (t == 4*DW) begin m_busy = 0; m_valid = 1; end
    end else if (m_valid) begin
      if (r) begin
        m_valid = 0;
        if (c) begin m_busy = 1; t = 0; end
      end
    end else if (s) begin
      m_busy = 1; t = 0;
    end
  endtask

  task automatic step(input bit s, input bit c, input bit r, input logic [3:0] iv);
    start = s; cont = c; out_ready = r; in_i = iv;
    model_edge(s, c, r, iv);
    @(posedge clk); #1;
    chk("sel",   8'({sel1, sel2}), m_busy ? 8'(t / DW) : 8'd0);
    chk("valid", 8'(out_valid), 8'(m_valid));
    chk("busy",  8'(busy), 8'(m_busy | m_valid));
    chk("data",  8'(data_out), 8'(m_data));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out", 8'({sel1, sel2, out_valid, busy}), 8'd0);
    chk("rst_data", 8'(data_out), 8'd0);
    model_clear();
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; cont = 0; out_ready = 0; in_i = 4'b0000;
    start1 = 0; out_ready1 = 0; in1 = 4'b1000;
    model_clear();
    #1;
    chk("reset_out", 8'({sel1, sel2, out_valid, busy}), 8'd0);
    chk("reset_data", 8'(data_out), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // i0..i3 = 1,0,1,1; start ignored mid-scan and in HOLD; 5 stall cycles
    tbl[0]  = '{1, 0, 0, 4'b1101, 2'd0, 0, 1, 4'b0000};
    tbl[1]  = '{0, 0, 0, 4'b1101, 2'd0, 0, 1, 4'b0000};
    tbl[2]  = '{0, 0, 0, 4'b1101, 2'd1, 0, 1, 4'b0001};
    tbl[3]  = '{0, 0, 0, 4'b1101, 2'd1, 0, 1, 4'b0001};
    tbl[4]  = '{1, 0, 0, 4'b1101, 2'd2, 0, 1, 4'b0001};
    tbl[5]  = '{0, 0, 0, 4'b1101, 2'd2, 0, 1, 4'b0001};
    tbl[6]  = '{0, 0, 0, 4'b1101, 2'd3, 0, 1, 4'b0101};
    tbl[7]  = '{0, 0, 0, 4'b1101, 2'd3, 0, 1, 4'b0101};
    tbl[8]  = '{0, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[9]  = '{0, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[10] = '{1, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[11] = '{0, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[12] = '{0, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[13] = '{0, 0, 0, 4'b1101, 2'd0, 1, 1, 4'b1101};
    tbl[14] = '{0, 0, 1, 4'b1101, 2'd0, 0, 0, 4'b1101};
    tbl[15] = '{0, 0, 0, 4'b1101, 2'd0, 0, 0, 4'b1101};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].iv);
      chk($sformatf("tbl%0d_sel", i), 8'({sel1, sel2}), 8'(tbl[i].sel));
      chk($sformatf("tbl%0d_vld", i), 8'({out_valid, busy}), 8'({tbl[i].v, tbl[i].b}));
      chk($sformatf("tbl%0d_dat", i), 8'(data_out), 8'(tbl[i].d));
    end

    // continuous mode, back-to-back scans; cont dropped mid second scan
    step(1, 1, 1, 4'b1101);
    repeat (8) step(0, 1, 1, 4'b1101);
    chk("cont_word1", 8'({out_valid, data_out}), 8'h1D);
    step(0, 1, 1, 4'b0110);
    chk("cont_no_idle", 8'({busy, out_valid}), 8'b10);
    repeat (4) step(0, 1, 1, 4'b0110);
    repeat (4) step(0, 0, 0, 4'b0110);
    chk("cont_word2", 8'({out_valid, data_out}), 8'h16);
    step(0, 0, 1, 4'b0110);
    chk("cont_end_idle", 8'({busy, out_valid, data_out}), 8'h06);

    // reset during channel 2, cont alone must not restart, then a clean scan
    step(1, 0, 0, 4'b0011);
    repeat (4) step(0, 0, 0, 4'b0011);
    chk("mid_ch2", 8'({sel1, sel2}), 8'd2);
    do_reset();
    repeat (3) step(0, 1, 1, 4'b0011);
    chk("no_cont_start", 8'({busy, out_valid}), 8'd0);
    step(1, 0, 0, 4'b0011);
    chk("first_start", 8'(busy), 8'd1);
    repeat (8) step(0, 0, 0, 4'b0011);
    chk("post_rst_word", 8'({out_valid, data_out}), 8'h13);
    step(0, 0, 1, 4'b0011);

    // DWELL=1: one edge per channel, word after 4 edges
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1;
    chk("d1_start", 8'({s1a, s1b, b1, v1}), 8'b0010);
    start1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) chk($sformatf("d1_sel%0d", k), 8'({s1a, s1b, v1}), 8'({2'(k), 1'b0}));
      else       chk("d1_word", 8'({v1, d1}), 8'h18);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    chk("d1_drop", 8'({v1, b1, d1}), 8'h08);
    out_ready1 = 1'b0;

    // random traffic against the model
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) != 0, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
